// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART state encoding, prescale constants and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int c_PRESCALE_W = 5;
    localparam int c_BIT_CNT_W  = 4;

    // A 5-bit field cannot hold 32, so 32 is carried as 0; the edge counter's
    // terminal value (prescale - 1) then wraps naturally to 31.
    localparam logic [c_PRESCALE_W-1:0] c_PRESCALE_8  = 5'd8;
    localparam logic [c_PRESCALE_W-1:0] c_PRESCALE_16 = 5'd16;
    localparam logic [c_PRESCALE_W-1:0] c_PRESCALE_32 = 5'd0;

    function automatic logic prescale_legal(input logic [c_PRESCALE_W-1:0] p);
        return (p == c_PRESCALE_8) || (p == c_PRESCALE_16) || (p == c_PRESCALE_32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_baud_counter.sv
`default_nettype none
// ============================================================================
// Module   : tx_baud_counter
// Purpose  : Per-bit edge counter and in-frame bit counter for the UART TX.
// Revision : 1.0 - initial release
// ============================================================================
module tx_baud_counter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic [c_PRESCALE_W-1:0] i_prescale,
    output logic                    o_bit_done,
    output logic                    o_last_data
);

    logic [c_PRESCALE_W-1:0] r_edge_cnt;
    logic [c_BIT_CNT_W-1:0]  r_bit_cnt;
    logic [c_PRESCALE_W-1:0] w_terminal;
    logic                    w_bit_done;

    assign w_terminal  = i_prescale - 5'd1;
    assign w_bit_done  = i_enable && (r_edge_cnt == w_terminal);
    assign o_bit_done  = w_bit_done;
    // Bit 0 of the frame is the start bit, so the last data bit sits at DATA_WIDTH.
    assign o_last_data = (r_bit_cnt == c_BIT_CNT_W'(DATA_WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!i_enable) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_bit_done) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else begin
            r_edge_cnt <= r_edge_cnt + 5'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter: start, LSB-first data, optional parity, stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   P_DATA,
    input  logic                    Data_Valid,
    input  logic                    PAR_EN,
    input  logic                    PAR_TYP,
    input  logic [c_PRESCALE_W-1:0] Prescale,
    output logic                    TX_OUT,
    output logic                    Busy
);

    uart_state_t             r_state, w_state_next;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic [c_PRESCALE_W-1:0] r_prescale;
    logic                    r_tx, r_busy;

    logic w_tx_next, w_busy_next, w_load, w_shift_en;
    logic w_bit_done, w_last_data, w_parity;

    tx_baud_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (r_state != ST_IDLE),
        .i_prescale  (r_prescale),
        .o_bit_done  (w_bit_done),
        .o_last_data (w_last_data)
    );

    assign w_parity = (^r_data) ^ r_par_typ;
    assign TX_OUT   = r_tx;
    assign Busy     = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
        end
    end

    // Outputs are decided one cycle ahead so TX_OUT/Busy change with the state.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_busy_next  = r_busy;
        w_load       = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (Data_Valid && prescale_legal(Prescale)) begin
                    w_state_next = ST_START;
                    w_load       = 1'b1;
                    w_tx_next    = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                    w_shift_en   = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (w_last_data) begin
                        w_state_next = r_par_en ? ST_PARITY : ST_STOP;
                        w_tx_next    = r_par_en ? w_parity : 1'b1;
                    end else begin
                        w_tx_next  = r_shift[0];
                        w_shift_en = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_next = ST_IDLE;
                    w_tx_next    = 1'b1;
                    w_busy_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_prescale <= '0;
        end else if (w_load) begin
            r_data     <= P_DATA;
            r_shift    <= P_DATA;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_prescale <= Prescale;
        end else if (w_shift_en) begin
            r_shift <= r_shift >> 1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Directed self-checking bench for uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [4:0] Prescale = 5'd8;
    logic       TX_OUT, Busy;

    int checks = 0;
    int errors = 0;

    logic cap_tx   [0:399];
    logic cap_busy [0:399];
    logic exp_bits [0:11];
    int   exp_len, exp_eff;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    // Reference frame: start 0, data LSB first, optional parity, stop 1.
    task automatic model_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
        exp_eff = (ps == 5'd0) ? 32 : int'(ps);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
        exp_len = 9;
        if (pe) begin
            exp_bits[9] = (^d) ^ pt;
            exp_len = 10;
        end
        exp_bits[exp_len] = 1'b1;
        exp_len++;
    endtask

    // Pulse Data_Valid over one rising edge; returns at the following falling edge.
    task automatic request(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
        @(negedge clk);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            cap_tx[k]   = TX_OUT;
            cap_busy[k] = Busy;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx: TX_OUT=%b expected 1", TX_OUT); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: Busy=%b expected 0", Busy); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: TX_OUT=%b Busy=%b expected 1/0", TX_OUT, Busy); end
    endtask

    task automatic test_frames;
        logic [7:0] td [4] = '{8'hA5, 8'h01, 8'hFF, 8'h00};
        logic       te [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       tt [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] tp [4] = '{5'd8, 5'd16, 5'd0, 5'd8};
        for (int v = 0; v < 4; v++) begin
            int hi, lo, flen;
            model_frame(td[v], te[v], tt[v], tp[v]);
            flen = exp_len * exp_eff;
            request(td[v], te[v], tt[v], tp[v]);
            capture(flen + 2);
            for (int b = 0; b < exp_len; b++) begin
                int bad;
                bad = 0;
                for (int c = 0; c < exp_eff; c++)
                    if (cap_tx[b*exp_eff + c] !== exp_bits[b]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL frame_%02h bit %0d: TX_OUT wrong in %0d of %0d cycles, expected %b",
                             td[v], b, bad, exp_eff, exp_bits[b]);
                end
            end
            hi = 0; lo = 0;
            for (int k = 0; k < flen; k++) if (cap_busy[k] === 1'b1) hi++;
            for (int k = flen; k < flen + 2; k++) if (cap_busy[k] !== 1'b0) lo++;
            checks++;
            if (hi != flen || lo != 0 || cap_tx[flen] !== 1'b1) begin
                errors++;
                $display("FAIL frame_%02h busy: busy cycles %0d expected %0d, busy after end %0d expected 0, idle tx %b expected 1",
                         td[v], hi, flen, lo, cap_tx[flen]);
            end
        end
    endtask

    task automatic test_illegal_prescale;
        logic [4:0] bad_ps [2] = '{5'd5, 5'd31};
        for (int v = 0; v < 2; v++) begin
            int bad;
            bad = 0;
            @(negedge clk);
            P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = bad_ps[v]; Data_Valid = 1'b1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (Busy !== 1'b0 || TX_OUT !== 1'b1) bad++;
            end
            Data_Valid = 1'b0;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL illegal_prescale_%0d: %0d of 100 cycles not idle, expected 0", bad_ps[v], bad);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] fd [2] = '{8'h55, 8'h3C};
        logic       fe [2] = '{1'b0, 1'b1};
        logic       ft [2] = '{1'b0, 1'b1};
        logic [4:0] fp [2] = '{5'd8, 5'd16};
        request(fd[0], fe[0], ft[0], fp[0]);
        for (int f = 0; f < 2; f++) begin
            int hi, lo, flen;
            model_frame(fd[f], fe[f], ft[f], fp[f]);
            flen = exp_len * exp_eff;
            if (f == 0) begin
                // A second request plus new config arrives mid-frame.
                fork
                    capture(flen + 2);
                    begin
                        repeat (20) @(negedge clk);
                        P_DATA = fd[1]; PAR_EN = fe[1]; PAR_TYP = ft[1]; Prescale = fp[1];
                        Data_Valid = 1'b1;
                        repeat (5) @(negedge clk);
                        Data_Valid = 1'b0;
                    end
                join
            end else begin
                capture(flen + 2);
            end
            for (int b = 0; b < exp_len; b++) begin
                int bad;
                bad = 0;
                for (int c = 0; c < exp_eff; c++)
                    if (cap_tx[b*exp_eff + c] !== exp_bits[b]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL b2b_%02h bit %0d: TX_OUT wrong in %0d of %0d cycles, expected %b",
                             fd[f], b, bad, exp_eff, exp_bits[b]);
                end
            end
            hi = 0; lo = 0;
            for (int k = 0; k < flen; k++) if (cap_busy[k] === 1'b1) hi++;
            for (int k = flen; k < flen + 2; k++) if (cap_busy[k] !== 1'b0) lo++;
            checks++;
            if (hi != flen || lo != 0 || cap_tx[flen] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%02h busy: busy cycles %0d expected %0d, busy after end %0d expected 0, idle tx %b expected 1",
                         fd[f], hi, flen, lo, cap_tx[flen]);
            end
            if (f == 0) begin
                Data_Valid = 1'b1;
                @(negedge clk);
                Data_Valid = 1'b0;
            end
        end
    endtask

    task automatic test_mid_frame_reset;
        int hi, lo, flen;
        request(8'hA5, 1'b1, 1'b0, 5'd8);
        // Land inside data bit 3 (frame bit 4, cycles 32..39), which is a 0.
        repeat (35) @(negedge clk);
        checks++;
        if (TX_OUT !== 1'b0 || Busy !== 1'b1)
            begin errors++; $display("FAIL pre_reset_bit3: TX_OUT=%b Busy=%b expected 0/1", TX_OUT, Busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            begin errors++; $display("FAIL async_reset: TX_OUT=%b Busy=%b expected 1/0", TX_OUT, Busy); end
        @(negedge clk);
        rst = 1'b0;
        model_frame(8'hA5, 1'b1, 1'b0, 5'd8);
        flen = exp_len * exp_eff;
        request(8'hA5, 1'b1, 1'b0, 5'd8);
        capture(flen + 2);
        for (int b = 0; b < exp_len; b++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < exp_eff; c++)
                if (cap_tx[b*exp_eff + c] !== exp_bits[b]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL after_reset bit %0d: TX_OUT wrong in %0d of %0d cycles, expected %b",
                         b, bad, exp_eff, exp_bits[b]);
            end
        end
        hi = 0; lo = 0;
        for (int k = 0; k < flen; k++) if (cap_busy[k] === 1'b1) hi++;
        for (int k = flen; k < flen + 2; k++) if (cap_busy[k] !== 1'b0) lo++;
        checks++;
        if (hi != flen || lo != 0)
            begin errors++; $display("FAIL after_reset busy: busy cycles %0d expected %0d, busy after end %0d expected 0", hi, flen, lo); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_illegal_prescale();
        test_back_to_back();
        test_mid_frame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, payload bits per frame.
REQ-002 Port: clk  in  1  single clock for all logic.
REQ-003 Port: rst  in  1  reset; one clock, reset is asynchronous and active-high.
REQ-004 Port: P_DATA  in  DATA_WIDTH  parallel byte to send.
REQ-005 Port: Data_Valid  in  1  request; P_DATA/PAR_EN/PAR_TYP qualify when high.
REQ-006 Port: PAR_EN  in  1  1 = parity bit inserted after data.
REQ-007 Port: PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-008 Port: Prescale  in  5  clk cycles per serial bit; legal values 8, 16, 32.
REQ-009 Port: TX_OUT  out  1  serial line, idle high.
REQ-010 Port: Busy  out  1  high while a frame is in progress.

Function
REQ-011 States IDLE, START, DATA, PARITY, STOP; all state, counters and outputs registered.
REQ-012 Accept: in IDLE, Data_Valid=1 and Prescale legal at an edge -> latch P_DATA, PAR_EN, PAR_TYP, Prescale; next state START.
REQ-013 Data_Valid while Busy=1 ignored; no queueing.
REQ-014 Data_Valid with illegal Prescale (anything other than 8/16/32) ignored; block stays IDLE, Busy=0, TX_OUT=1.
REQ-015 TX_OUT=0 and Busy=1 from the first cycle after the accept edge.
REQ-016 Every bit (start, data, parity, stop) held exactly latched-Prescale cycles; edge counter runs 0..Prescale-1, then wraps to 0 and advances the bit counter.
REQ-017 Frame order: start(0), DATA_WIDTH data bits LSB first, parity if PAR_EN, stop(1).
REQ-018 Parity = XOR of latched data for even; inverted XOR for odd; computed from the latched byte, not live P_DATA.
REQ-019 DATA -> PARITY when PAR_EN latched 1, else DATA -> STOP.
REQ-020 After the last stop cycle -> IDLE; Busy=0, TX_OUT=1 on that same next cycle. Minimum 1 IDLE cycle between frames.
REQ-021 Frame length is (DATA_WIDTH+2+PAR_EN) x Prescale cycles of TX_OUT≠idle-state timing; Busy high exactly that many cycles.
REQ-022 Changes to P_DATA, PAR_EN, PAR_TYP or Prescale mid-frame have no effect on the current frame.
REQ-023 Bit counter 4 bits, edge counter 5 bits; no overflow within legal configurations.

Reset
REQ-024 rst=1 -> asynchronously: state IDLE, counters 0, TX_OUT=1, Busy=0, latched data/config 0.
REQ-025 Reset mid-frame aborts the frame immediately; first Data_Valid after rst deassert accepted normally.

Structure
REQ-026 Shared package uart_pkg holds state encoding and the prescale constants 8/16/32 (reused by the RX side).
REQ-027 One sub-module tx_baud_counter: edge/bit counting with bit_done and frame-position outputs; FSM, shift register and parity remain in uart_tx.

Verification
REQ-028 P_DATA=0xA5, PAR_EN=1 even, Prescale=8 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,0,1, each 8 cycles; Busy high 88 cycles.
REQ-029 P_DATA=0x01, PAR_EN=1 odd, Prescale=16 -> parity bit 0; frame 176 cycles; stop bit high.
REQ-030 P_DATA=0xFF, PAR_EN=0, Prescale=32 -> 10 bits, 320 Busy cycles, no parity slot.
REQ-031 Prescale=5 with Data_Valid=1 -> Busy stays 0, TX_OUT stays 1 for 100 cycles.
REQ-032 Second Data_Valid (0x3C) during frame of 0x55 -> only 0x55 sent; 0x3C re-asserted after Busy falls is sent next.
REQ-033 rst pulsed at data bit 3 -> TX_OUT=1, Busy=0 immediately; subsequent 0xA5 frame matches REQ-028.
